// File: rtl/axi_mmu_sram_slv.sv
// AXI4 subordinate with SMMU stream/substream tagging, backed by a resettable
// 64-bit word register memory. Independent single-outstanding read and write paths.

package ariane_axi_soc;
   localparam int unsigned IdWidth = 4;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [63:0]        addr;
      logic [7:0]         len;
      logic [2:0]         size;
      logic [1:0]         burst;
      logic               lock;
      logic [3:0]         cache;
      logic [2:0]         prot;
      logic [3:0]         qos;
      logic [3:0]         region;
      logic [5:0]         atop;
      logic [0:0]         user;
      logic [23:0]        stream_id;
      logic               ss_id_valid;
      logic [19:0]        substream_id;
   } aw_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [63:0]        addr;
      logic [7:0]         len;
      logic [2:0]         size;
      logic [1:0]         burst;
      logic               lock;
      logic [3:0]         cache;
      logic [2:0]         prot;
      logic [3:0]         qos;
      logic [3:0]         region;
      logic [0:0]         user;
      logic [23:0]        stream_id;
      logic               ss_id_valid;
      logic [19:0]        substream_id;
   } ar_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic [0:0]  user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [1:0]         resp;
      logic [0:0]         user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [63:0]        data;
      logic [1:0]         resp;
      logic               last;
      logic [0:0]         user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_mmu_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module axi_mmu_sram_slv #(
   parameter logic [63:0] BaseAddr = 64'h0,
   parameter int unsigned NumWords = 256
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic [$bits(ariane_axi_soc::req_mmu_t)-1:0] axi_req_i,
   output logic [$bits(ariane_axi_soc::resp_t)-1:0]    axi_resp_o,
   output logic [23:0]                                  aw_sid_o,
   output logic [20:0]                                  aw_ssid_o,
   output logic [23:0]                                  ar_sid_o,
   output logic [20:0]                                  ar_ssid_o
);
   import ariane_axi_soc::*;

   localparam int unsigned IdxW       = $clog2(NumWords);
   localparam logic [63:0] EndAddr    = BaseAddr + 64'(NumWords) * 64'd8;
   localparam logic [1:0]  BurstFixed = 2'b00;
   localparam logic [1:0]  BurstWrap  = 2'b10;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   req_mmu_t req;
   resp_t    resp;
   logic     unused_req;

   assign req        = req_mmu_t'(axi_req_i);
   assign axi_resp_o = resp;
   assign unused_req = ^req;

   function automatic logic addr_err(input logic [63:0] a);
      return (a < BaseAddr) || (a >= EndAddr);
   endfunction

   function automatic logic [IdxW-1:0] word_idx(input logic [63:0] a);
      logic [63:0] off;
      off = (a - BaseAddr) >> 3;
      return off[IdxW-1:0];
   endfunction

   function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
      if (burst == BurstFixed) return a;
      return a + (64'd1 << size);
   endfunction

   function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] data,
                                               input logic [7:0] strb);
      logic [63:0] res;
      for (int b = 0; b < 8; b++) res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
      return res;
   endfunction

   logic [63:0] mem [NumWords];

   w_state_e    w_state, w_state_nx;
   logic [3:0]  w_id;
   logic [63:0] w_addr;
   logic [7:0]  w_cnt;
   logic [2:0]  w_size;
   logic [1:0]  w_burst;
   logic        w_bad, w_err;

   r_state_e    r_state, r_state_nx;
   logic [3:0]  r_id;
   logic [63:0] r_addr, r_data;
   logic [7:0]  r_cnt;
   logic [2:0]  r_size;
   logic [1:0]  r_burst, r_resp;
   logic        r_bad;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic        w_beat_err, ar_bad_in, ar_err0, r_next_err;
   logic [63:0] r_next_addr;

   assign aw_hs = req.aw_valid && (w_state == W_IDLE);
   assign w_hs  = req.w_valid  && (w_state == W_DATA);
   assign b_hs  = req.b_ready  && (w_state == W_RESP);
   assign ar_hs = req.ar_valid && (r_state == R_IDLE);
   assign r_hs  = req.r_ready  && (r_state == R_DATA);

   // Burst-level faults poison every beat; range faults are judged per beat.
   assign w_beat_err  = w_bad || addr_err(w_addr);
   assign ar_bad_in   = (req.ar.burst == BurstWrap) || (req.ar.size > 3'd3);
   assign ar_err0     = ar_bad_in || addr_err(req.ar.addr);
   assign r_next_addr = next_addr(r_addr, r_size, r_burst);
   assign r_next_err  = r_bad || addr_err(r_next_addr);

   always_comb begin
      w_state_nx = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
         W_DATA:  if (w_hs && (w_cnt == 8'd0)) w_state_nx = W_RESP;
         W_RESP:  if (b_hs) w_state_nx = W_IDLE;
         default: w_state_nx = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nx = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
         R_DATA:  if (r_hs && (r_cnt == 8'd0)) r_state_nx = R_IDLE;
         default: r_state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state   <= W_IDLE;
         w_id      <= '0;
         w_addr    <= '0;
         w_cnt     <= '0;
         w_size    <= '0;
         w_burst   <= '0;
         w_bad     <= 1'b0;
         w_err     <= 1'b0;
         aw_sid_o  <= '0;
         aw_ssid_o <= '0;
         for (int i = 0; i < int'(NumWords); i++) mem[i] <= '0;
      end else begin
         w_state <= w_state_nx;
         if (aw_hs) begin
            w_id      <= req.aw.id;
            w_addr    <= req.aw.addr;
            w_cnt     <= req.aw.len;
            w_size    <= req.aw.size;
            w_burst   <= req.aw.burst;
            w_bad     <= (req.aw.burst == BurstWrap) || (req.aw.size > 3'd3) || (req.aw.atop != 6'd0);
            w_err     <= 1'b0;
            aw_sid_o  <= req.aw.stream_id;
            aw_ssid_o <= {req.aw.ss_id_valid, req.aw.substream_id};
         end
         if (w_hs) begin
            if (w_beat_err) w_err <= 1'b1;
            else mem[word_idx(w_addr)] <= merge_bytes(mem[word_idx(w_addr)], req.w.data, req.w.strb);
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt - 8'd1;
         end
      end
   end

   // Read data is captured from the pre-write memory contents, giving read-before-write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= R_IDLE;
         r_id      <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_cnt     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_resp    <= RespOkay;
         r_bad     <= 1'b0;
         ar_sid_o  <= '0;
         ar_ssid_o <= '0;
      end else begin
         r_state <= r_state_nx;
         if (ar_hs) begin
            r_id      <= req.ar.id;
            r_addr    <= req.ar.addr;
            r_cnt     <= req.ar.len;
            r_size    <= req.ar.size;
            r_burst   <= req.ar.burst;
            r_bad     <= ar_bad_in;
            r_data    <= ar_err0 ? 64'd0 : mem[word_idx(req.ar.addr)];
            r_resp    <= ar_err0 ? RespSlvErr : RespOkay;
            ar_sid_o  <= req.ar.stream_id;
            ar_ssid_o <= {req.ar.ss_id_valid, req.ar.substream_id};
         end
         if (r_hs && (r_cnt != 8'd0)) begin
            r_addr <= r_next_addr;
            r_cnt  <= r_cnt - 8'd1;
            r_data <= r_next_err ? 64'd0 : mem[word_idx(r_next_addr)];
            r_resp <= r_next_err ? RespSlvErr : RespOkay;
         end
      end
   end

   always_comb begin
      resp          = '0;
      resp.aw_ready = (w_state == W_IDLE);
      resp.w_ready  = (w_state == W_DATA);
      resp.b_valid  = (w_state == W_RESP);
      resp.b.id     = w_id;
      resp.b.resp   = w_err ? RespSlvErr : RespOkay;
      resp.ar_ready = (r_state == R_IDLE);
      resp.r_valid  = (r_state == R_DATA);
      resp.r.id     = r_id;
      resp.r.data   = r_data;
      resp.r.resp   = r_resp;
      resp.r.last   = (r_state == R_DATA) && (r_cnt == 8'd0);
   end
endmodule
